// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine and its FIFO.
package uart_pkg;

    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_DIV_W      = 16;
    localparam int unsigned DATA_W         = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_e;

    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input parity_mode_e mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with registered level/ready/empty and show-ahead read data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data_c,
    output logic              o_empty,
    output logic [LVL_W-1:0]  o_level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_wr_ready;
    logic              r_empty;

    logic              w_push;
    logic              w_pop;
    logic [AW:0]       w_wr_nxt;
    logic [AW:0]       w_rd_nxt;
    logic              w_full_nxt;

    assign w_push = i_wr_valid & r_wr_ready;
    assign w_pop  = i_rd_en & ~r_empty;

    // Pointers carry one extra MSB so equal low bits mean empty (MSB equal) or full (MSB differs).
    assign w_wr_nxt   = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_nxt   = r_rd_ptr + (AW+1)'(w_pop);
    assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_wr_ready <= 1'b1;
            r_empty    <= 1'b1;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_level    <= LVL_W'(w_wr_nxt - w_rd_nxt);
            r_wr_ready <= ~w_full_nxt;
            r_empty    <= (w_wr_nxt == w_rd_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data_c = r_mem[r_rd_ptr[AW-1:0]];
    assign o_wr_ready  = r_wr_ready;
    assign o_empty     = r_empty;
    assign o_level     = r_level;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO-fed framer with per-frame latched baud divisor and parity mode.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int unsigned DIV_W      = DEF_DIV_W,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              busy,
    output logic              uart_tx,
    output logic              tx_clk
);

    tx_state_e         r_state;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_uart_tx;
    logic              r_tx_clk;
    logic              r_busy;

    logic              w_fifo_empty;
    logic [7:0]        w_rd_data;
    logic              w_bit_end;
    logic              w_pop;
    logic              w_tx_bit;
    logic              w_tx_clk;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_data   (wr_data),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_rd_en     (w_pop),
        .o_rd_data_c (w_rd_data),
        .o_empty     (w_fifo_empty),
        .o_level     (fifo_level)
    );

    assign w_bit_end = (r_baud_cnt == r_div);
    // Pop when idle, or on the last STOP cycle so the next frame follows with no gap.
    assign w_pop     = ~w_fifo_empty & ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    always_comb begin
        w_tx_bit = 1'b1;
        case (r_state)
            START:   w_tx_bit = 1'b0;
            DATA:    w_tx_bit = r_shift[0];
            PARITY:  w_tx_bit = r_par_bit;
            default: w_tx_bit = 1'b1;
        endcase
    end

    // High for the first ceil((div+1)/2) cycles of each bit.
    assign w_tx_clk = (r_state != IDLE) && (r_baud_cnt <= (r_div >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_uart_tx  <= 1'b1;
            r_tx_clk   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_uart_tx <= w_tx_bit;
            r_tx_clk  <= w_tx_clk;
            r_busy    <= (r_state != IDLE);

            if (w_pop) begin
                r_state    <= START;
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
                r_shift    <= w_rd_data;
                r_div      <= div;
                r_par_en   <= parity_en;
                r_par_bit  <= parity_bit(w_rd_data, parity_mode_e'(parity_odd));
            end else if (r_state != IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + DIV_W'(1);
                if (w_bit_end) begin
                    case (r_state)
                        START: begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                        DATA: begin
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= r_par_en ? PARITY : STOP;
                            end
                        end
                        PARITY:  r_state <= STOP;
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign uart_tx = r_uart_tx;
    assign tx_clk  = r_tx_clk;
    assign busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] div;
    logic        parity_en;
    logic        parity_odd;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  fifo_level;
    logic        busy;
    logic        uart_tx;
    logic        tx_clk;

    int tests = 0;
    int fails = 0;

    uart_tx_engine #(
        .FIFO_DEPTH (8),
        .DIV_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div        (div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .uart_tx    (uart_tx),
        .tx_clk     (tx_clk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        wr_data  = d;
        wr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_frame_start(input string tag);
        int n;
        n = 0;
        while (uart_tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_start", tag), 32'(uart_tx), 32'd0);
    endtask

    // Entered at the negedge showing the first start-bit cycle; leaves at the negedge after the frame.
    task automatic check_frame(input string tag, input int dv, input logic [7:0] data,
                               input logic pe, input logic pbit);
        logic [10:0] bits;
        int nb;
        int per;
        per = dv + 1;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        bits[8:1] = data;
        if (pe) begin
            bits[9] = pbit;
            nb = 11;
        end else begin
            nb = 10;
        end
        for (int i = 0; i < nb * per; i++) begin
            chk($sformatf("%s_tx[%0d]", tag, i), 32'(uart_tx), 32'(bits[i / per]));
            chk($sformatf("%s_txclk[%0d]", tag, i), 32'(tx_clk), 32'((i % per) < ((per + 1) / 2)));
            chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy), 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        int acc;
        int maxlvl;
        int n;
        int bad;

        rst_n      = 1'b0;
        div        = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        wr_data    = 8'h00;
        wr_valid   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_tx_clk", 32'(tx_clk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, div=3, no parity; exact two-cycle latency from the write edge
        div = 16'd3;
        write_byte(8'hA5);
        chk("a5_lat0", 32'(uart_tx), 32'd1);
        @(negedge clk);
        chk("a5_lat1", 32'(uart_tx), 32'd1);
        @(negedge clk);
        check_frame("a5", 3, 8'hA5, 1'b0, 1'b0);
        chk("a5_end_busy", 32'(busy), 32'd0);
        chk("a5_end_tx", 32'(uart_tx), 32'd1);
        chk("a5_end_txclk", 32'(tx_clk), 32'd0);

        // 0x07, div=1, even then odd parity
        div        = 16'd1;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        write_byte(8'h07);
        wait_frame_start("peven");
        check_frame("peven", 1, 8'h07, 1'b1, 1'b1);
        chk("peven_end_busy", 32'(busy), 32'd0);
        parity_odd = 1'b1;
        write_byte(8'h07);
        wait_frame_start("podd");
        check_frame("podd", 1, 8'h07, 1'b1, 1'b0);
        chk("podd_end_busy", 32'(busy), 32'd0);

        // Divisor change mid-frame applies only to the following frame
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        div        = 16'd3;
        write_byte(8'h3C);
        write_byte(8'h81);
        wait_frame_start("mid");
        div = 16'd7;
        check_frame("mid1", 3, 8'h3C, 1'b0, 1'b0);
        check_frame("mid2", 7, 8'h81, 1'b0, 1'b0);
        chk("mid_end_busy", 32'(busy), 32'd0);

        // div=0: one-cycle bits, tx_clk high throughout
        div = 16'd0;
        write_byte(8'hFF);
        wait_frame_start("ff");
        check_frame("ff", 0, 8'hFF, 1'b0, 1'b0);
        chk("ff_end_busy", 32'(busy), 32'd0);
        chk("ff_end_txclk", 32'(tx_clk), 32'd0);

        // Fill: ten back-to-back writes at div=15
        div    = 16'd15;
        acc    = 0;
        maxlvl = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_data  = 8'h10 + 8'(i);
            wr_valid = 1'b1;
            if (wr_ready === 1'b1) acc++;
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            @(posedge clk);
        end
        @(negedge clk);
        chk("full_accepted", 32'(acc), 32'd9);
        chk("full_maxlvl", 32'(maxlvl), 32'd8);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd8);
        n = 0;
        while (wr_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("full_hold_cycles", 32'(n), 32'd152);
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("full_refill_level", 32'(fifo_level), 32'd8);
        chk("full_refill_ready", 32'(wr_ready), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("full_busy_run", 32'(n), 32'd1440);
        chk("full_end_level", 32'(fifo_level), 32'd0);

        // Reset during DATA with three bytes queued
        div = 16'd3;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        repeat (4) @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        chk("rst_pre_level", 32'(fifo_level), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(uart_tx), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_level", 32'(fifo_level), 32'd0);
        chk("rst_mid_txclk", 32'(tx_clk), 32'd0);
        chk("rst_mid_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("rst_no_frames", 32'(bad), 32'd0);
        chk("rst_post_level", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter DIV_W, default 16, width of baud divisor.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port div  input  DIV_W  bit period = div+1 clk cycles.
REQ-006 SHALL have port parity_en  input  1  1 = insert parity bit after data.
REQ-007 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even.
REQ-008 SHALL have port wr_data  input  8  byte to transmit.
REQ-009 SHALL have port wr_valid  input  1  write request.
REQ-010 SHALL have port wr_ready  output  1  FIFO not full; write accepted when wr_valid&wr_ready.
REQ-011 SHALL have port fifo_level  output  log2(FIFO_DEPTH)+1  entries held.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port uart_tx  output  1  serial line, idle high, registered.
REQ-014 SHALL have port tx_clk  output  1  registered bit-rate strobe for debug-probe sampling.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; frame = start(0), 8 data LSB-first, optional parity, 1 stop(1).
REQ-016 SHALL, in IDLE with FIFO non-empty, pop one byte, latch div/parity_en/parity_odd, and enter START; config changes mid-frame take effect next frame only.
REQ-017 SHALL drive uart_tx low 2 cycles after the accepting write edge when idle with empty FIFO (1 cycle pop, 1 cycle output register).
REQ-018 SHALL hold each bit for exactly div+1 cycles; div=0 gives 1-cycle bits.
REQ-019 SHALL skip PARITY when latched parity_en=0; parity bit = XOR(data) ^ parity_odd.
REQ-020 SHALL, at end of STOP with FIFO non-empty, start next frame with no idle gap; otherwise return to IDLE.
REQ-021 SHALL drive tx_clk high for the first ceil((div+1)/2) cycles of every bit period, low for the remainder, and low in IDLE, aligned with uart_tx transitions.
REQ-022 SHALL assert busy from the START entry through last STOP cycle.
REQ-023 SHALL deassert wr_ready when fifo_level = FIFO_DEPTH, registered; a write while full is dropped without state change.
REQ-024 SHALL, on simultaneous write and pop, keep fifo_level unchanged; write into empty FIFO is not popped the same cycle.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH using an extra MSB for full/empty.

Reset
REQ-026 SHALL on rst_n low asynchronously set: FSM IDLE, FIFO empty, fifo_level 0, wr_ready 1, busy 0, uart_tx 1, tx_clk 0, counters 0.
REQ-027 SHALL abandon any in-progress frame on reset (uart_tx returns high immediately; queued bytes discarded).

Structure
REQ-028 SHALL place FSM state enum, parity-mode constants and default DIV_W/FIFO_DEPTH in shared package uart_pkg.
REQ-029 SHALL instantiate one sub-module uart_tx_fifo (synchronous FIFO, same clk/rst_n); baud counter, shifter and FSM stay in uart_tx_engine.

Verification
REQ-030 SHALL check div=3, parity_en=0, write 0xA5 -> uart_tx 0,1,0,1,0,0,1,0,1,1 each 4 cycles, tx_clk high 2 of each 4, busy 40 cycles.
REQ-031 SHALL check div=1, parity_en=1, parity_odd=0, write 0x07 -> parity bit 1, frame 22 cycles; parity_odd=1 -> parity bit 0.
REQ-032 SHALL check div=15, 10 back-to-back writes -> 9 accepted, fifo_level reaches 8, wr_ready 0 until first frame completes, 10th then accepted; frames contiguous.
REQ-033 SHALL check div changed from 3 to 7 mid-frame -> current frame keeps 4-cycle bits, next frame uses 8-cycle bits.
REQ-034 SHALL check rst_n pulsed low during DATA with 3 bytes queued -> uart_tx 1, busy 0, fifo_level 0 immediately; no further frames.
REQ-035 SHALL check div=0, write 0xFF -> 10-cycle frame, tx_clk high every frame cycle.
